// File: rtl/dram_slot_sched.sv
// dram_slot_sched: splits each PHI2 cycle into two DRAM slots (A: S1-S3,
// B: S5-S7) and grants them to CBR refresh, the CPU window or a DMA engine.
// Every DRAM strobe is a flop output.
module dram_slot_sched #(
    parameter int REF_DIV = 13
) (
    input  logic DotClk,
    input  logic RESET,
    input  logic PHI2,
    input  logic CpuSel,
    input  logic CpuWr,
    input  logic DmaReq,
    input  logic DmaWr,
    output logic RASr,
    output logic CASr,
    output logic RWEr,
    output logic RAsel,
    output logic DmaSel,
    output logic DmaAck,
    output logic RefBusy
);

    typedef enum logic [1:0] {SA_IDLE, SA_REF, SA_DMA} slot_a_e;
    typedef enum logic [1:0] {SB_IDLE, SB_CPU, SB_DMA} slot_b_e;

    localparam logic [7:0] RC_TOP = 8'(REF_DIV - 1);

    // PHI2 synchroniser and phase tracking
    logic       phi2_sync_q, phi2_sync_d;
    logic       phi2_prev_q, phi2_prev_d;
    logic       seen_q, seen_d;
    logic [3:0] s_q, s_d;
    logic [7:0] rc_q, rc_d;
    logic       ref_pend_q, ref_pend_d;

    // slot ownership, latched at slot entry
    slot_a_e    slot_a_q, slot_a_d;
    slot_b_e    slot_b_q, slot_b_d;
    logic       wr_a_q, wr_a_d;
    logic       wr_b_q, wr_b_d;

    // registered strobes
    logic       ras_q, ras_d;
    logic       cas_q, cas_d;
    logic       rwe_q, rwe_d;
    logic       rasel_q, rasel_d;
    logic       dmasel_q, dmasel_d;
    logic       dma_ack_q, dma_ack_d;
    logic       refbusy_q, refbusy_d;

    logic       fall;
    logic       early;

    // Sync regs reset high, so a reset-time low never looks like a falling edge
    // until a genuine low sample has been recorded in seen_q.
    assign fall  = phi2_prev_q & ~phi2_sync_q & seen_q;
    // A fall mid-cycle (not the first sync, not a stalled/normal end) is a glitch.
    assign early = fall && (s_q != 4'd0) && (s_q < 4'd7);

    // Phase counter, refresh cadence and slot grants
    always_comb begin
        phi2_sync_d = PHI2;
        phi2_prev_d = phi2_sync_q;
        seen_d      = seen_q | ~phi2_sync_q;
        s_d         = s_q;
        rc_d        = rc_q;
        ref_pend_d  = ref_pend_q;
        slot_a_d    = slot_a_q;
        slot_b_d    = slot_b_q;
        wr_a_d      = wr_a_q;
        wr_b_d      = wr_b_q;

        if (fall) begin
            s_d = 4'd1;
        end else if (s_q != 4'd0 && s_q != 4'd15) begin
            s_d = s_q + 4'd1;
        end

        // S only passes 2 once per synced cycle, so a stalled PHI2 freezes RC.
        if (s_q == 4'd2) begin
            if (rc_q == RC_TOP) begin
                rc_d       = 8'd0;
                ref_pend_d = 1'b1;
            end else begin
                rc_d = rc_q + 8'd1;
            end
        end

        if (fall) begin
            // Entering S1: any slot-B access is over (or aborted by a glitch).
            slot_a_d = SA_IDLE;
            slot_b_d = SB_IDLE;
            // A glitch resync leaves the whole cycle's slot A idle.
            if (!early) begin
                if (ref_pend_q) begin
                    slot_a_d   = SA_REF;
                    ref_pend_d = 1'b0;
                end else if (DmaReq && !dma_ack_q) begin
                    // DmaReq seen during its own ack cycle is the old transaction.
                    slot_a_d = SA_DMA;
                    wr_a_d   = DmaWr;
                end
            end
        end else if (s_q == 4'd4) begin
            if (CpuSel) begin
                slot_b_d = SB_CPU;
                wr_b_d   = CpuWr;
            end else if (DmaReq) begin
                slot_b_d = SB_DMA;
                wr_b_d   = DmaWr;
            end else begin
                slot_b_d = SB_IDLE;
            end
        end
    end

    // Strobe pattern for the phase being entered, so flops hold it during S=k
    always_comb begin
        ras_d     = 1'b0;
        cas_d     = 1'b0;
        rwe_d     = 1'b0;
        rasel_d   = 1'b0;
        dmasel_d  = 1'b0;
        dma_ack_d = 1'b0;
        refbusy_d = 1'b0;
        case (s_d)
            4'd1, 4'd2, 4'd3: begin
                if (slot_a_d == SA_REF) begin
                    // CAS-before-RAS refresh
                    cas_d     = (s_d != 4'd3);
                    ras_d     = (s_d != 4'd1);
                    refbusy_d = 1'b1;
                end else if (slot_a_d == SA_DMA) begin
                    ras_d     = 1'b1;
                    rasel_d   = (s_d != 4'd1);
                    cas_d     = (s_d == 4'd3);
                    rwe_d     = (s_d == 4'd3) && wr_a_d;
                    dmasel_d  = 1'b1;
                    dma_ack_d = (s_d == 4'd3);
                end
            end
            4'd5, 4'd6, 4'd7: begin
                if (slot_b_d != SB_IDLE) begin
                    ras_d     = 1'b1;
                    rasel_d   = (s_d != 4'd5);
                    cas_d     = (s_d == 4'd7);
                    rwe_d     = (s_d == 4'd7) && wr_b_d;
                    dmasel_d  = (slot_b_d == SB_DMA);
                    dma_ack_d = (s_d == 4'd7) && (slot_b_d == SB_DMA);
                end
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge DotClk) begin
        if (RESET) begin
            phi2_sync_q <= 1'b1;
            phi2_prev_q <= 1'b1;
            seen_q      <= 1'b0;
            s_q         <= 4'd0;
            rc_q        <= 8'd0;
            ref_pend_q  <= 1'b0;
            slot_a_q    <= SA_IDLE;
            slot_b_q    <= SB_IDLE;
            wr_a_q      <= 1'b0;
            wr_b_q      <= 1'b0;
            ras_q       <= 1'b0;
            cas_q       <= 1'b0;
            rwe_q       <= 1'b0;
            rasel_q     <= 1'b0;
            dmasel_q    <= 1'b0;
            dma_ack_q   <= 1'b0;
            refbusy_q   <= 1'b0;
        end else begin
            phi2_sync_q <= phi2_sync_d;
            phi2_prev_q <= phi2_prev_d;
            seen_q      <= seen_d;
            s_q         <= s_d;
            rc_q        <= rc_d;
            ref_pend_q  <= ref_pend_d;
            slot_a_q    <= slot_a_d;
            slot_b_q    <= slot_b_d;
            wr_a_q      <= wr_a_d;
            wr_b_q      <= wr_b_d;
            ras_q       <= ras_d;
            cas_q       <= cas_d;
            rwe_q       <= rwe_d;
            rasel_q     <= rasel_d;
            dmasel_q    <= dmasel_d;
            dma_ack_q   <= dma_ack_d;
            refbusy_q   <= refbusy_d;
        end
    end

    assign RASr    = ras_q;
    assign CASr    = cas_q;
    assign RWEr    = rwe_q;
    assign RAsel   = rasel_q;
    assign DmaSel  = dmasel_q;
    assign DmaAck  = dma_ack_q;
    assign RefBusy = refbusy_q;

endmodule

// File: tb/tb_dram_slot_sched.sv
// Directed bench for dram_slot_sched: per-PHI2-cycle vector table plus
// hand sequences for reset, PHI2 stall and glitch resync.
module tb_dram_slot_sched;

    localparam int A_I = 0, A_REF = 1, A_DRD = 2, A_DWR = 3;
    localparam int B_I = 0, B_CRD = 1, B_CWR = 2, B_DRD = 3, B_DWR = 4;

    typedef struct {
        logic cpu_sel;
        logic cpu_wr;
        int   dma_n;
        logic dma_wr;
        int   ea;
        int   eb;
    } vec_t;

    logic DotClk = 1'b0;
    logic RESET, PHI2, CpuSel, CpuWr, DmaReq, DmaWr;
    logic RASr, CASr, RWEr, RAsel, DmaSel, DmaAck, RefBusy;
    logic [6:0] outs;

    int errs = 0;
    int checks = 0;
    int outstanding = 0;
    int acks = 0;
    int bursts = 0;
    int nz;
    logic ref_prev = 1'b0;
    vec_t tab [1:40];

    always #5 DotClk = ~DotClk;

    dram_slot_sched #(.REF_DIV(13)) dut (
        .DotClk(DotClk), .RESET(RESET), .PHI2(PHI2),
        .CpuSel(CpuSel), .CpuWr(CpuWr), .DmaReq(DmaReq), .DmaWr(DmaWr),
        .RASr(RASr), .CASr(CASr), .RWEr(RWEr), .RAsel(RAsel),
        .DmaSel(DmaSel), .DmaAck(DmaAck), .RefBusy(RefBusy)
    );

    assign outs = {RASr, CASr, RWEr, RAsel, DmaSel, DmaAck, RefBusy};

    // count refresh bursts by RefBusy rising edges
    always @(negedge DotClk) begin
        if (RefBusy && !ref_prev) bursts <= bursts + 1;
        ref_prev <= RefBusy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic cs, logic cw, int dn, logic dw, int ea, int eb);
        vec_t v;
        v.cpu_sel = cs; v.cpu_wr = cw; v.dma_n = dn; v.dma_wr = dw; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    // expected {RAS,CAS,RWE,RAsel,DmaSel,DmaAck,RefBusy} during phase s
    function automatic logic [6:0] exp_out(int s, int a, int b);
        logic ras, cas, rwe, rasel, dsel, ack, rb;
        ras = 0; cas = 0; rwe = 0; rasel = 0; dsel = 0; ack = 0; rb = 0;
        if (s >= 1 && s <= 3 && a == A_REF) begin
            cas = (s <= 2); ras = (s >= 2); rb = 1;
        end
        if (s >= 1 && s <= 3 && (a == A_DRD || a == A_DWR)) begin
            ras = 1; rasel = (s >= 2); cas = (s == 3);
            rwe = (s == 3) && (a == A_DWR); dsel = 1; ack = (s == 3);
        end
        if (s >= 5 && s <= 7 && b != B_I) begin
            ras = 1; rasel = (s >= 6); cas = (s == 7);
            rwe = (s == 7) && (b == B_CWR || b == B_DWR);
            dsel = (b == B_DRD || b == B_DWR); ack = dsel && (s == 7);
        end
        return {ras, cas, rwe, rasel, dsel, ack, rb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one DotClk; the DMA engine reacts to DmaAck at the sample point
    task automatic tick();
        @(posedge DotClk);
        @(negedge DotClk);
        if (DmaAck === 1'b1) begin
            outstanding--;
            acks++;
            DmaReq = (outstanding > 0);
        end
    endtask

    task automatic apply(input vec_t v);
        CpuSel = v.cpu_sel;
        CpuWr  = v.cpu_wr;
        if (v.dma_n > 0) begin
            outstanding += v.dma_n;
            DmaWr = v.dma_wr;
        end
        DmaReq = (outstanding > 0);
    endtask

    // one 8-DotClk PHI2 cycle: low 4, high 4; S=1 lands on the second edge
    task automatic phi2_cycle(input vec_t v, input string tag);
        int s;
        PHI2 = 1'b0;
        apply(v);
        for (int i = 0; i < 8; i++) begin
            tick();
            s = (i == 0) ? 8 : i;
            chk($sformatf("%s s%0d", tag, s), 32'(outs), 32'(exp_out(s, v.ea, v.eb)));
            if (i == 3) PHI2 = 1'b1;
        end
    endtask

    task automatic clear_tab();
        for (int c = 1; c <= 40; c++) tab[c] = mk(0, 0, 0, 0, A_I, B_I);
    endtask

    task automatic run_tab(input int n, input string tag);
        for (int c = 1; c <= n; c++) phi2_cycle(tab[c], $sformatf("%s c%0d", tag, c));
    endtask

    // PHI2 low long enough to be seen, then high, ready for a first sync
    task automatic presync();
        nz = 0;
        PHI2 = 1'b0;
        repeat (3) begin tick(); if (outs != 0) nz++; end
        PHI2 = 1'b1;
        repeat (4) begin tick(); if (outs != 0) nz++; end
    endtask

    initial begin
        RESET = 1; PHI2 = 0; CpuSel = 0; CpuWr = 0; DmaReq = 0; DmaWr = 0;
        repeat (3) tick();
        chk("reset outs", 32'(outs), 0);
        RESET = 0;
        tick();
        chk("reset S", 32'(dut.s_q), 0);
        chk("reset RC", 32'(dut.rc_q), 0);
        presync();
        chk("presync idle", nz, 0);
        chk("presync S", 32'(dut.s_q), 0);

        // 40 cycles: refresh at 14/27/40, traffic and collisions in between
        clear_tab();
        tab[2]  = mk(1, 0, 0, 0, A_I,   B_CRD);
        tab[3]  = mk(1, 1, 0, 0, A_I,   B_CWR);
        tab[4]  = mk(0, 0, 1, 0, A_DRD, B_I);
        tab[5]  = mk(0, 0, 1, 1, A_DWR, B_I);
        tab[6]  = mk(1, 0, 2, 0, A_DRD, B_CRD);
        tab[7]  = mk(0, 0, 0, 0, A_DRD, B_I);
        tab[8]  = mk(0, 0, 2, 1, A_DWR, B_DWR);
        tab[13] = mk(0, 0, 1, 0, A_DRD, B_I);
        tab[14] = mk(0, 0, 1, 0, A_REF, B_DRD);
        tab[27] = mk(1, 1, 1, 1, A_REF, B_CWR);
        tab[28] = mk(0, 0, 0, 0, A_DWR, B_I);
        tab[40] = mk(0, 0, 0, 0, A_REF, B_I);
        run_tab(40, "t1");
        chk("t1 refresh bursts", bursts, 3);
        chk("t1 acks", acks, 9);
        chk("t1 outstanding", outstanding, 0);

        // reset during DMA slot A: no ack, request survives and is re-served
        PHI2 = 0;
        apply(mk(0, 0, 1, 0, A_DRD, B_I));
        tick();
        tick();
        chk("pre-reset S1", 32'(outs), 32'(exp_out(1, A_DRD, B_I)));
        RESET = 1;
        nz = 0;
        repeat (3) begin tick(); if (outs != 0) nz++; end
        chk("in-reset outs", nz, 0);
        RESET = 0;
        tick();
        chk("post-reset outs", 32'(outs), 0);
        chk("post-reset RC", 32'(dut.rc_q), 0);
        chk("post-reset S", 32'(dut.s_q), 0);
        chk("reset no ack", acks, 9);
        presync();
        chk("post-reset idle", nz, 0);
        clear_tab();
        tab[1]  = mk(0, 0, 0, 0, A_DRD, B_I);
        tab[14] = mk(0, 0, 0, 0, A_REF, B_I);
        run_tab(14, "t2");
        chk("t2 refresh bursts", bursts, 4);
        chk("t2 acks", acks, 10);

        // PHI2 stuck high with both requesters waiting
        CpuSel = 1; CpuWr = 0;
        apply(mk(1, 0, 1, 0, A_I, B_I));
        nz = 0;
        repeat (40) begin tick(); if (outs != 0) nz++; end
        chk("stall strobes", nz, 0);
        chk("stall S", 32'(dut.s_q), 15);
        chk("stall RC frozen", 32'(dut.rc_q), 1);
        phi2_cycle(mk(1, 0, 0, 0, A_DRD, B_CRD), "poststall");
        chk("poststall acks", acks, 11);

        // glitch: PHI2 falls again while a slot-B DMA is at S5
        PHI2 = 0;
        apply(mk(0, 0, 0, 0, A_I, B_I));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("gl s%0d", (i == 0) ? 8 : i), 32'(outs), 0);
        end
        PHI2 = 1;
        apply(mk(0, 0, 1, 0, A_I, B_I));
        tick();
        chk("gl s4", 32'(outs), 0);
        PHI2 = 0;
        tick();
        chk("gl s5", 32'(outs), 32'(exp_out(5, A_I, B_DRD)));
        tick();
        chk("gl resync outs", 32'(outs), 0);
        chk("gl resync S", 32'(dut.s_q), 1);
        chk("gl no ack", acks, 11);
        for (int k = 2; k <= 7; k++) begin
            tick();
            chk($sformatf("gl r s%0d", k), 32'(outs), 32'(exp_out(k, A_I, B_DRD)));
            if (k == 3) PHI2 = 1;
        end
        phi2_cycle(mk(0, 0, 0, 0, A_I, B_I), "recover");
        chk("final acks", acks, 12);
        chk("final outstanding", outstanding, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
